// File: rtl/mips_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
//   md_op_e    : 2-bit op encoding as presented on the op port
//   md_state_e : multiply/divide sequencer states
//   MD_XLEN    : default operand / HI / LO width
package mips_pkg;

   localparam int MD_XLEN = 32;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DIV  = 2'b10,
      ST_FIX  = 2'b11
   } md_state_e;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign handling shared by multiply and divide.
// Entry side : turns raw operands into magnitudes plus sign flags.
// Exit side  : restores signs on the unsigned iteration result.
//   sign_op          in   operation is signed (MULT/DIV)
//   rs_val, rt_val   in   raw operands
//   rs_abs, rt_abs   out  magnitudes (raw values for unsigned ops)
//   rs_neg, rt_neg   out  operand is negative (always 0 for unsigned ops)
//   is_div           in   result being fixed belongs to a divide
//   res_neg          in   product / quotient must be negated
//   rem_neg          in   remainder must be negated (dividend was negative)
//   acc_hi, acc_lo   in   unsigned result: product halves or remainder/quotient
//   fix_hi, fix_lo   out  signed result for HI / LO
module muldiv_sign_fix #(
   parameter int XLEN = 32
) (
   input  logic            sign_op,
   input  logic [XLEN-1:0] rs_val,
   input  logic [XLEN-1:0] rt_val,
   output logic [XLEN-1:0] rs_abs,
   output logic [XLEN-1:0] rt_abs,
   output logic            rs_neg,
   output logic            rt_neg,
   input  logic            is_div,
   input  logic            res_neg,
   input  logic            rem_neg,
   input  logic [XLEN-1:0] acc_hi,
   input  logic [XLEN-1:0] acc_lo,
   output logic [XLEN-1:0] fix_hi,
   output logic [XLEN-1:0] fix_lo
);

   logic [2*XLEN-1:0] prod;
   logic [2*XLEN-1:0] prod_fix;

   assign rs_neg = sign_op & rs_val[XLEN-1];
   assign rt_neg = sign_op & rt_val[XLEN-1];
   // The most negative value maps onto itself, which is its correct unsigned magnitude.
   assign rs_abs = rs_neg ? -rs_val : rs_val;
   assign rt_abs = rt_neg ? -rt_val : rt_val;

   // Product sign is applied across the full double-width value.
   assign prod     = {acc_hi, acc_lo};
   assign prod_fix = res_neg ? -prod : prod;

   always_comb begin
      // NOTE: every output gets a value on every path so no latch is inferred.
      fix_hi = prod_fix[2*XLEN-1:XLEN];
      fix_lo = prod_fix[XLEN-1:0];
      if (is_div) begin
         fix_lo = res_neg ? -acc_lo : acc_lo;
         fix_hi = rem_neg ? -acc_hi : acc_hi;
      end
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit owning the HI/LO register pair.
// Radix-2 shift-add multiply and restoring divide, XLEN iterations each,
// followed by a single sign-fix/write-back cycle.
//   clk, rst_n         clock, asynchronous active-low reset
//   start, en_ex, op   op request from ID/EX (op: MULT, MULTU, DIV, DIVU)
//   rs_val, rt_val     operands after forwarding
//   flush              squash any in-flight op
//   hilo_rd            EX instruction reads HI/LO (MFHI/MFLO)
//   hi_we, lo_we,
//   wr_val             MTHI/MTLO write port
//   hi, lo             architectural HI/LO
//   busy               op in flight
//   done               1-cycle pulse when an op updated HI/LO
//   stall_req          hold IF/ID and ID/EX while a HI/LO user waits
module ex_muldiv_unit
   import mips_pkg::*;
#(
   parameter int XLEN  = MD_XLEN,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            en_ex,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rs_val,
   input  logic [XLEN-1:0] rt_val,
   input  logic            flush,
   input  logic            hilo_rd,
   input  logic            hi_we,
   input  logic            lo_we,
   input  logic [XLEN-1:0] wr_val,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo,
   output logic            busy,
   output logic            done,
   output logic            stall_req
);

   md_state_e        state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0]  acc_hi;    // partial product high half / running remainder
   logic [XLEN-1:0]  acc_lo;    // multiplier bits / dividend bits becoming quotient
   logic [XLEN-1:0]  opb;       // multiplicand / divisor magnitude
   logic             res_neg;
   logic             rem_neg;
   logic             div0;
   logic             is_div;

   logic             accept;
   logic             last_iter;
   logic [XLEN-1:0]  rs_abs, rt_abs;
   logic             rs_neg, rt_neg;
   logic [XLEN-1:0]  fix_hi, fix_lo;
   logic [XLEN:0]    mul_sum;
   logic [XLEN:0]    div_shift;
   logic [XLEN-1:0]  div_diff;
   logic             div_ge;

   assign accept    = (state == ST_IDLE) & start & en_ex & ~flush;
   assign last_iter = (cnt == CNT_W'(XLEN - 1));
   assign busy      = (state != ST_IDLE);
   assign stall_req = busy & (start | hilo_rd | hi_we | lo_we);

   muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
      .sign_op (~op[0]),
      .rs_val  (rs_val),
      .rt_val  (rt_val),
      .rs_abs  (rs_abs),
      .rt_abs  (rt_abs),
      .rs_neg  (rs_neg),
      .rt_neg  (rt_neg),
      .is_div  (is_div),
      .res_neg (res_neg),
      .rem_neg (rem_neg),
      .acc_hi  (acc_hi),
      .acc_lo  (acc_lo),
      .fix_hi  (fix_hi),
      .fix_lo  (fix_lo)
   );

   // Multiply step: add multiplicand when the current multiplier bit is set,
   // then shift the whole {carry, acc_hi, acc_lo} right by one.
   assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);

   // Divide step: bring the next dividend bit into the remainder and subtract
   // the divisor if it fits. The remainder stays below the divisor, so the
   // difference always fits in XLEN bits. A zero divisor yields an all-ones
   // quotient and a remainder equal to the dividend magnitude.
   assign div_shift = {acc_hi, acc_lo[XLEN-1]};
   assign div_ge    = (div_shift >= {1'b0, opb});
   assign div_diff  = div_shift[XLEN-1:0] - opb;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept) state_nxt = op[1] ? ST_DIV : ST_MUL;
         ST_MUL,
         ST_DIV: begin
            if (flush)          state_nxt = ST_IDLE;
            else if (last_iter) state_nxt = ST_FIX;
         end
         ST_FIX:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         acc_hi  <= '0;
         acc_lo  <= '0;
         opb     <= '0;
         res_neg <= 1'b0;
         rem_neg <= 1'b0;
         div0    <= 1'b0;
         is_div  <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         done    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  cnt     <= '0;
                  acc_hi  <= '0;
                  acc_lo  <= rs_abs;
                  opb     <= rt_abs;
                  res_neg <= rs_neg ^ rt_neg;
                  rem_neg <= rs_neg;
                  div0    <= op[1] & (rt_val == '0);
                  is_div  <= op[1];
               end
               // MTHI/MTLO only land while idle; otherwise the stall holds them.
               if (hi_we) hi <= wr_val;
               if (lo_we) lo <= wr_val;
            end
            ST_MUL: begin
               acc_hi <= mul_sum[XLEN:1];
               acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
               cnt    <= cnt + 1'b1;
            end
            ST_DIV: begin
               acc_hi <= div_ge ? div_diff : div_shift[XLEN-1:0];
               acc_lo <= {acc_lo[XLEN-2:0], div_ge};
               cnt    <= cnt + 1'b1;
            end
            ST_FIX: begin
               // Sign-restored remainder of a divide-by-zero is the raw dividend.
               if (!flush) begin
                  hi   <= fix_hi;
                  lo   <= div0 ? '1 : fix_lo;
                  done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit.
module tb_ex_muldiv_unit;
   import mips_pkg::*;

   localparam int XLEN = 32;
   localparam int LAT  = XLEN + 2;

   logic            clk;
   logic            rst_n;
   logic            start;
   logic            en_ex;
   logic [1:0]      op;
   logic [XLEN-1:0] rs_val;
   logic [XLEN-1:0] rt_val;
   logic            flush;
   logic            hilo_rd;
   logic            hi_we;
   logic            lo_we;
   logic [XLEN-1:0] wr_val;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;
   logic            busy;
   logic            done;
   logic            stall_req;

   int n_cmp  = 0;
   int n_fail = 0;

   ex_muldiv_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .en_ex     (en_ex),
      .op        (op),
      .rs_val    (rs_val),
      .rt_val    (rt_val),
      .flush     (flush),
      .hilo_rd   (hilo_rd),
      .hi_we     (hi_we),
      .lo_we     (lo_we),
      .wr_val    (wr_val),
      .hi        (hi),
      .lo        (lo),
      .busy      (busy),
      .done      (done),
      .stall_req (stall_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one op, then wait (bounded) for done and check latency and result.
   task automatic do_op(input string tag, input logic [1:0] o,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] exp_hi, input logic [XLEN-1:0] exp_lo);
      int k;
      @(negedge clk);
      start = 1'b1; op = o; rs_val = a; rt_val = b;
      @(negedge clk);
      start = 1'b0;
      check({tag, " busy"}, 64'(busy), 64'd1);
      k = 1;
      while (!done && k < 40) begin
         @(negedge clk);
         k++;
      end
      check({tag, " latency"}, 64'(k), 64'(LAT));
      check({tag, " busy_at_done"}, 64'(busy), 64'd0);
      check({tag, " hi"}, 64'(hi), 64'(exp_hi));
      check({tag, " lo"}, 64'(lo), 64'(exp_lo));
      @(negedge clk);
      check({tag, " done_pulse"}, 64'(done), 64'd0);
   endtask

   initial begin
      int k;
      int n_done;
      rst_n = 1'b0; start = 1'b0; en_ex = 1'b1; op = MD_MULT;
      rs_val = '0; rt_val = '0; flush = 1'b0; hilo_rd = 1'b0;
      hi_we = 1'b0; lo_we = 1'b0; wr_val = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      check("rst hi", 64'(hi), 64'd0);
      check("rst lo", 64'(lo), 64'd0);
      check("rst busy", 64'(busy), 64'd0);
      check("rst done", 64'(done), 64'd0);
      check("rst stall", 64'(stall_req), 64'd0);

      // MTLO in idle: no stall, written on the next edge.
      lo_we = 1'b1; wr_val = 32'h0000_1234;
      #1 check("mtlo stall", 64'(stall_req), 64'd0);
      @(negedge clk);
      lo_we = 1'b0;
      check("mtlo lo", 64'(lo), 64'h1234);
      check("mtlo hi_untouched", 64'(hi), 64'd0);

      do_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      do_op("mult_neg",  MD_MULT,  32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
      do_op("div_neg",   MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
      do_op("div_negdv", MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
      do_op("divu_by0",  MD_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF);
      do_op("div_by0",   MD_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
      do_op("div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      do_op("divu_big",  MD_DIVU,  32'hFFFF_FFFF, 32'd10,        32'd5,         32'h1999_9999);

      // MFHI one cycle after MULT: stalled 33 cycles, then sees the new HI.
      @(negedge clk);
      start = 1'b1; op = MD_MULT; rs_val = 32'd5; rt_val = 32'hFFFF_FFFC;
      @(negedge clk);
      start = 1'b0; hilo_rd = 1'b1;
      k = 0;
      while (stall_req && k < 40) begin
         k++;
         @(negedge clk);
      end
      check("mfhi stall_cycles", 64'(k), 64'd33);
      check("mfhi hi", 64'(hi), 64'hFFFF_FFFF);
      check("mfhi lo", 64'(lo), 64'hFFFF_FFEC);
      check("mfhi done", 64'(done), 64'd1);
      hilo_rd = 1'b0;
      @(negedge clk);

      // MTHI and MTLO together in idle.
      hi_we = 1'b1; lo_we = 1'b1; wr_val = 32'h5A5A_0F0F;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b0;
      check("mthilo hi", 64'(hi), 64'h5A5A_0F0F);
      check("mthilo lo", 64'(lo), 64'h5A5A_0F0F);

      // Flush at cycle 10 of a DIV.
      start = 1'b1; op = MD_DIV; rs_val = 32'd1000; rt_val = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush busy", 64'(busy), 64'd0);
      check("flush done", 64'(done), 64'd0);
      check("flush hi", 64'(hi), 64'h5A5A_0F0F);
      check("flush lo", 64'(lo), 64'h5A5A_0F0F);

      // Flush in the same cycle as start: op ignored.
      start = 1'b1; flush = 1'b1; op = MD_DIVU; rs_val = 32'd9; rt_val = 32'd3;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("flush_start busy", 64'(busy), 64'd0);
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) n_done++;
      end
      check("flush no_done", 64'(n_done), 64'd0);
      check("flush hi_kept", 64'(hi), 64'h5A5A_0F0F);

      // Async reset at cycle 20 of a MULTU.
      start = 1'b1; op = MD_MULTU; rs_val = 32'h10; rt_val = 32'h10;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      check("pre_rst busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("async_rst hi", 64'(hi), 64'd0);
      check("async_rst lo", 64'(lo), 64'd0);
      check("async_rst busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      do_op("multu_after_rst", MD_MULTU, 32'h1234_5678, 32'h10, 32'h0000_0001, 32'h2345_6780);

      // MTHI while busy: stalled, applied only after the op writes HI/LO.
      @(negedge clk);
      start = 1'b1; op = MD_MULTU; rs_val = 32'd2; rt_val = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      hi_we = 1'b1; wr_val = 32'hDEAD_0001;
      #1 check("mthi_busy stall", 64'(stall_req), 64'd1);
      k = 5;
      while (!done && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("mthi_busy latency", 64'(k), 64'(LAT));
      check("mthi_busy hi_op", 64'(hi), 64'd0);
      check("mthi_busy lo_op", 64'(lo), 64'd6);
      check("mthi_busy stall_off", 64'(stall_req), 64'd0);
      @(negedge clk);
      hi_we = 1'b0;
      check("mthi_busy hi_applied", 64'(hi), 64'hDEAD_0001);
      check("mthi_busy lo_kept", 64'(lo), 64'd6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
